// File: rtl/perf_pkg.sv
// Shared constants, lock FSM states and helpers for the performance counter bank.
package perf_pkg;

    localparam int MODE_WRAP   = 0;
    localparam int MODE_SAT    = 1;

    localparam int SEL_CYCLES  = 0;
    localparam int SEL_EV_BASE = 1;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/perf_counter_bank_if.sv
// Control, readout and status signals between the pipeline and the counter bank.
interface perf_counter_bank_if #(
    parameter int N_EV  = 5,
    parameter int WIDTH = 32
) ();
    import perf_pkg::*;

    localparam int SEL_W = clog2(N_EV + 1);

    logic              halt;
    logic [N_EV-1:0]   ev;
    logic              clr;
    logic              snap;
    logic [SEL_W-1:0]  rd_sel;
    logic              rd_snap;
    logic [WIDTH-1:0]  rd_data;
    logic [WIDTH-1:0]  cycles;
    logic [N_EV:0]     ovf;
    logic              lock;

    modport master (
        output halt, ev, clr, snap, rd_sel, rd_snap,
        input  rd_data, cycles, ovf, lock
    );

    modport slave (
        input  halt, ev, clr, snap, rd_sel, rd_snap,
        output rd_data, cycles, ovf, lock
    );

endinterface

// File: rtl/perf_ctr.sv
// One counter lane: adds inc when enabled, wraps or saturates, sticky overflow.
module perf_ctr
    import perf_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] inc,
    output logic [WIDTH-1:0] cnt,
    output logic             ovf
);

    logic [WIDTH:0] sum;

    assign sum = {1'b0, cnt} + {1'b0, inc};

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (en) begin
            if (sum[WIDTH] && (SATURATE == MODE_SAT)) cnt <= '1;
            else                                      cnt <= sum[WIDTH-1:0];
            if (sum[WIDTH]) ovf <= 1'b1;
        end
    end

endmodule

// File: rtl/perf_counter_bank.sv
// Cycle counter plus N_EV event counters with snapshot bank, registered readout
// and a halt lock.
//   state     | meaning
//   ST_RUN    | counting cycles and events
//   ST_LOCKED | halt seen; counters frozen until reset (clr still honoured)
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int N_EV       = 5,
    parameter int WIDTH      = 32,
    parameter int SATURATE   = MODE_WRAP,
    parameter int HALT_EXTRA = 2
) (
    input  logic              clk,
    input  logic              rst,
    perf_counter_bank_if.slave bus
);

    localparam int               SEL_W   = clog2(N_EV + 1);
    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(N_EV);

    lock_state_t      state_q;
    lock_state_t      state_nx;
    logic             run;
    logic [WIDTH-1:0] cyc_inc;
    logic [WIDTH-1:0] live   [N_EV+1];
    logic [WIDTH-1:0] snap_q [N_EV+1];
    logic             ovf_a  [N_EV+1];

    always_ff @(posedge clk) begin
        if (!rst) state_q <= ST_RUN;
        else      state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        if (state_q == ST_RUN && bus.halt) state_nx = ST_LOCKED;
    end

    assign run       = (state_q == ST_RUN);
    assign bus.lock  = (state_q == ST_LOCKED);
    // The first halt cycle accounts for the drain of the pipeline.
    assign cyc_inc   = bus.halt ? WIDTH'(HALT_EXTRA) : WIDTH'(1);

    perf_ctr #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_cyc (
        .clk (clk),
        .rst (rst),
        .clr (bus.clr),
        .en  (run),
        .inc (cyc_inc),
        .cnt (live[SEL_CYCLES]),
        .ovf (ovf_a[SEL_CYCLES])
    );

    for (genvar i = 0; i < N_EV; i++) begin : g_ev
        perf_ctr #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_ev (
            .clk (clk),
            .rst (rst),
            .clr (bus.clr),
            .en  (run && bus.ev[i]),
            .inc (WIDTH'(1)),
            .cnt (live[SEL_EV_BASE+i]),
            .ovf (ovf_a[SEL_EV_BASE+i])
        );
    end

    always_comb begin
        bus.ovf = '0;
        for (int k = 0; k <= N_EV; k++) bus.ovf[k] = ovf_a[k];
    end

    assign bus.cycles = live[SEL_CYCLES];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k <= N_EV; k++) snap_q[k] <= '0;
        end else if (bus.snap) begin
            for (int k = 0; k <= N_EV; k++) snap_q[k] <= live[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)                        bus.rd_data <= '0;
        else if (bus.rd_sel > SEL_MAX)   bus.rd_data <= '0;
        else if (bus.rd_snap)            bus.rd_data <= snap_q[bus.rd_sel];
        else                             bus.rd_data <= live[bus.rd_sel];
    end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: three configurations driven in lockstep against a reference model.
module tb_perf_counter_bank;

    localparam int NE = 5;
    localparam int HX = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    perf_counter_bank_if #(.N_EV(NE), .WIDTH(32)) b0 ();
    perf_counter_bank_if #(.N_EV(NE), .WIDTH(4))  b1 ();
    perf_counter_bank_if #(.N_EV(NE), .WIDTH(4))  b2 ();

    perf_counter_bank #(.N_EV(NE), .WIDTH(32), .SATURATE(0), .HALT_EXTRA(HX)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    perf_counter_bank #(.N_EV(NE), .WIDTH(4),  .SATURATE(1), .HALT_EXTRA(HX)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    perf_counter_bank #(.N_EV(NE), .WIDTH(4),  .SATURATE(0), .HALT_EXTRA(HX)) dut2 (.clk(clk), .rst(rst), .bus(b2));

    int n_checks = 0;
    int n_fails  = 0;

    logic          halt, clr, snap, rd_snap;
    logic [NE-1:0] ev;
    logic [2:0]    rd_sel;

    longint unsigned m_live [3][NE+1];
    longint unsigned m_snap [3][NE+1];
    bit              m_ovf  [3][NE+1];
    longint unsigned m_rd   [3];
    bit              m_lock;
    int              mw [3] = '{32, 4, 4};
    int              ms [3] = '{0, 1, 0};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add(input int d, input int c, input int inc);
        longint unsigned maxv, s;
        maxv = (64'd1 << mw[d]) - 64'd1;
        s = m_live[d][c] + longint'(inc);
        if (s > maxv) begin
            m_ovf[d][c] = 1'b1;
            m_live[d][c] = (ms[d] == 1) ? maxv : (s & maxv);
        end else begin
            m_live[d][c] = s;
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 3; d++) begin
            if (!rst) begin
                for (int c = 0; c <= NE; c++) begin
                    m_live[d][c] = 0; m_snap[d][c] = 0; m_ovf[d][c] = 0;
                end
                m_rd[d] = 0;
            end else begin
                if (rd_sel > NE)  m_rd[d] = 0;
                else if (rd_snap) m_rd[d] = m_snap[d][rd_sel];
                else              m_rd[d] = m_live[d][rd_sel];
                if (snap)
                    for (int c = 0; c <= NE; c++) m_snap[d][c] = m_live[d][c];
                if (clr) begin
                    for (int c = 0; c <= NE; c++) begin
                        m_live[d][c] = 0; m_ovf[d][c] = 0;
                    end
                end else if (!m_lock) begin
                    add(d, 0, halt ? HX : 1);
                    for (int i = 0; i < NE; i++) if (ev[i]) add(d, i + 1, 1);
                end
            end
        end
        if (!rst)      m_lock = 1'b0;
        else if (halt) m_lock = 1'b1;
    endtask

    task automatic chk_dut(input int d, input logic [63:0] cyc, input logic [63:0] ovf,
                           input logic lk, input logic [63:0] rd);
        logic [63:0] e_ovf;
        e_ovf = '0;
        for (int c = 0; c <= NE; c++) e_ovf[c] = m_ovf[d][c];
        chk($sformatf("d%0d cycles", d), cyc, m_live[d][0]);
        chk($sformatf("d%0d ovf", d), ovf, e_ovf);
        chk($sformatf("d%0d lock", d), {63'b0, lk}, {63'b0, m_lock});
        chk($sformatf("d%0d rd_data", d), rd, m_rd[d]);
    endtask

    task automatic drive();
        b0.halt = halt; b0.ev = ev; b0.clr = clr; b0.snap = snap; b0.rd_sel = rd_sel; b0.rd_snap = rd_snap;
        b1.halt = halt; b1.ev = ev; b1.clr = clr; b1.snap = snap; b1.rd_sel = rd_sel; b1.rd_snap = rd_snap;
        b2.halt = halt; b2.ev = ev; b2.clr = clr; b2.snap = snap; b2.rd_sel = rd_sel; b2.rd_snap = rd_snap;
    endtask

    task automatic tick();
        drive();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk_dut(0, 64'(b0.cycles), 64'(b0.ovf), b0.lock, 64'(b0.rd_data));
        chk_dut(1, 64'(b1.cycles), 64'(b1.ovf), b1.lock, 64'(b1.rd_data));
        chk_dut(2, 64'(b2.cycles), 64'(b2.ovf), b2.lock, 64'(b2.rd_data));
    endtask

    initial begin
        m_lock = 1'b0;
        for (int d = 0; d < 3; d++) begin
            m_rd[d] = 0;
            for (int c = 0; c <= NE; c++) begin
                m_live[d][c] = 0; m_snap[d][c] = 0; m_ovf[d][c] = 0;
            end
        end

        // reset with halt and all events asserted
        rst = 1'b0; halt = 1'b1; ev = '1; clr = 1'b0; snap = 1'b0; rd_sel = 3'd0; rd_snap = 1'b0;
        repeat (2) tick();
        chk("reset cycles", 64'(b0.cycles), 64'd0);
        chk("reset ovf", 64'(b0.ovf), 64'd0);
        chk("reset lock", 64'(b0.lock), 64'd0);
        chk("reset rd_data", 64'(b0.rd_data), 64'd0);

        // run counting
        rst = 1'b1; halt = 1'b0;
        for (int c = 0; c < 10; c++) begin
            ev = '0;
            ev[2] = 1'b1;
            ev[0] = (c % 3 == 0) && (c < 9);
            tick();
        end
        chk("run cycles", 64'(b0.cycles), 64'd10);
        ev = '0;
        rd_sel = 3'd1; tick(); chk("run ch0", 64'(b0.rd_data), 64'd3);
        rd_sel = 3'd3; tick(); chk("run ch2", 64'(b0.rd_data), 64'd10);
        rd_sel = 3'd2; tick(); chk("run ch1", 64'(b0.rd_data), 64'd0);

        // halt freeze
        rst = 1'b0; tick(); rst = 1'b1;
        repeat (4) tick();
        halt = 1'b1; ev = '1;
        tick();
        chk("halt lock", 64'(b0.lock), 64'd1);
        repeat (5) tick();
        chk("halt cycles", 64'(b0.cycles), 64'd6);
        for (int k = 1; k <= NE; k++) begin
            rd_sel = 3'(k);
            tick();
            chk($sformatf("halt ch%0d", k - 1), 64'(b0.rd_data), 64'd1);
        end
        chk("halt cycles held", 64'(b0.cycles), 64'd6);

        // saturate / wrap at WIDTH=4
        halt = 1'b0; ev = '0; rst = 1'b0; tick(); rst = 1'b1;
        ev = 5'b00001;
        repeat (20) tick();
        ev = '0; rd_sel = 3'd1;
        tick();
        chk("sat ch0", 64'(b1.rd_data), 64'd15);
        chk("sat ovf1", 64'(b1.ovf[1]), 64'd1);
        chk("wrap ch0", 64'(b2.rd_data), 64'd4);
        chk("wrap ovf1", 64'(b2.ovf[1]), 64'd1);
        chk("wide ch0", 64'(b0.rd_data), 64'd20);

        // snap and clr together
        rst = 1'b0; tick(); rst = 1'b1;
        ev = 5'b00001;
        repeat (7) tick();
        snap = 1'b1; clr = 1'b1;
        tick();
        snap = 1'b0; clr = 1'b0; ev = '0;
        chk("collide ovf", 64'(b0.ovf), 64'd0);
        chk("collide cycles", 64'(b0.cycles), 64'd0);
        rd_sel = 3'd1; rd_snap = 1'b0; tick(); chk("collide live ch0", 64'(b0.rd_data), 64'd0);
        rd_snap = 1'b1;                tick(); chk("collide snap ch0", 64'(b0.rd_data), 64'd7);
        rd_snap = 1'b0;

        // reset while locked
        halt = 1'b1; tick();
        chk("relock lock", 64'(b0.lock), 64'd1);
        halt = 1'b0; rst = 1'b0; tick(); rst = 1'b1;
        repeat (3) tick();
        chk("unlock lock", 64'(b0.lock), 64'd0);
        chk("unlock cycles", 64'(b0.cycles), 64'd3);
        rd_sel = 3'(NE + 1); tick(); chk("sel out of range", 64'(b0.rd_data), 64'd0);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            rst     = ($urandom_range(0, 39) != 0);
            halt    = ($urandom_range(0, 29) == 0);
            ev      = NE'($urandom);
            clr     = ($urandom_range(0, 24) == 0);
            snap    = ($urandom_range(0, 7) == 0);
            rd_sel  = 3'($urandom_range(0, 7));
            rd_snap = 1'($urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
